instr_mem_pipe: RTL and testbench
=================================

INSTR_MEM_PIPE -- requirements
Module: instr_mem_pipe

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, meaning instruction word width in bits.
REQ-002 The module SHALL have parameter ADDR_W, default 32, meaning byte-address width of the fetch and load ports.
REQ-003 The module SHALL have parameter DEPTH, default 64, meaning number of instruction words stored (power of 2, 4..4096).
REQ-004 The module SHALL have parameter LATENCY, default 1, meaning read pipeline stages (legal values 1 or 2).
REQ-005 Port list SHALL be as follows (clock and reset first; reset is asynchronous, active-low):
- clk  in  1  sole clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  module accepts fetch this cycle.
- req_pc  in  ADDR_W  fetch byte address.
- rsp_valid  out  1  fetched instruction available.
- rsp_ready  in  1  consumer accepts response.
- rsp_instr  out  DATA_W  fetched instruction word.
- rsp_pc  out  ADDR_W  byte address belonging to rsp_instr.
- rsp_err  out  1  fetch was misaligned or out of range.
- ld_en  in  1  program-load write strobe.
- ld_addr  in  ADDR_W  program-load byte address.
- ld_data  in  DATA_W  program-load word.

Function
REQ-006 Storage SHALL be DEPTH words of DATA_W bits; word index = address >> 2.
REQ-007 A fetch SHALL be accepted on a rising edge where req_valid and req_ready are both 1.
REQ-008 req_ready SHALL equal (!rsp_valid || rsp_ready) combined with the stage-1 occupancy for LATENCY=2, i.e. the pipeline advances only when the output stage is empty or being drained.
REQ-009 An accepted fetch SHALL appear on rsp_* exactly LATENCY cycles later if the pipeline never stalls.
REQ-010 While rsp_valid=1 and rsp_ready=0, rsp_instr, rsp_pc and rsp_err SHALL hold stable and no pipeline stage SHALL advance.
REQ-011 Responses SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-012 req_pc[1:0]!=0 SHALL give rsp_err=1 and rsp_instr=0.
REQ-013 A word index >= DEPTH SHALL give rsp_err=1 and rsp_instr=0.
REQ-014 Otherwise rsp_err SHALL be 0 and rsp_instr SHALL be the stored word.
REQ-015 ld_en=1 with aligned, in-range ld_addr SHALL write ld_data at the next rising edge, independent of the fetch handshake.
REQ-016 Misaligned or out-of-range loads SHALL be ignored silently.
REQ-017 Load and fetch of the same word in the same cycle SHALL return the old word (read-before-write).
REQ-018 Address index wrap SHALL NOT occur; high address bits SHALL be checked, not truncated.
REQ-019 Throughput SHALL be one fetch per cycle when rsp_ready is held at 1.

Reset
REQ-020 While rst_n=0: rsp_valid=0, rsp_instr=0, rsp_pc=0, rsp_err=0, and all internal stage-valid flags=0.
REQ-021 req_ready SHALL be 1 during and immediately after reset.
REQ-022 Memory contents SHALL NOT be cleared by reset; unloaded words are undefined.
REQ-023 Reset asserted mid-operation SHALL discard all in-flight fetches; no response to them SHALL appear after release.
REQ-024 Loads SHALL be ignored while rst_n=0.

Verification
REQ-025 Load 0x20110014 at byte address 4, fetch pc=4 with rsp_ready=1 -> after LATENCY cycles rsp_valid=1, rsp_instr=0x20110014, rsp_pc=4, rsp_err=0.
REQ-026 Fetch pc=6, then pc=4*DEPTH -> both responses have rsp_err=1 and rsp_instr=0; ld_addr=4*DEPTH with ld_en=1 leaves all words unchanged.
REQ-027 Back-to-back fetches pc=0,4,8,12 with rsp_ready=1 -> four consecutive responses, one per cycle, in order.
REQ-028 Hold rsp_ready=0 for 3 cycles with pc=0,4 queued -> rsp_* stable, req_ready=0 while full; release -> pc=0 response then pc=4 response, no loss.
REQ-029 In one cycle, load 0xDEADBEEF at address 8 and fetch pc=8 (old 0x20120024) -> rsp_instr=0x20120024; next fetch of pc=8 -> 0xDEADBEEF.
REQ-030 Assert rst_n=0 with 2 fetches in flight -> rsp_valid=0 immediately; after release no stale response appears and the next fetch behaves per REQ-009.

Source files
------------

// File: rtl/instr_mem_pipe.sv
// Instruction memory with a valid/ready fetch port and a word-wide program-load port.
// The read pipeline is 1 or 2 stages deep; misaligned or out-of-range accesses return an error.
module instr_mem_pipe #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_pc,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_instr,
    output logic [ADDR_W-1:0] rsp_pc,
    output logic              rsp_err,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_reg;

    // The full address is compared, so high bits can never alias onto a valid word.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a[1:0] == 2'b00) && ((a >> 2) < ADDR_W'(DEPTH));
    endfunction

    logic             req_fire;
    logic             req_bad;
    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] ld_idx;
    logic             ld_ok;

    assign req_fire = req_valid && req_ready;
    assign req_bad  = !addr_ok(req_pc);
    assign req_idx  = req_pc[IDX_W+1:2];
    assign ld_idx   = ld_addr[IDX_W+1:2];
    assign ld_ok    = ld_en && addr_ok(ld_addr);

    // Contents survive reset; the reset edge only suppresses writes while asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n) begin
            if (ld_ok) begin
                mem[ld_idx] <= ld_data;
            end
        end
    end

    // Non-blocking read alongside the write gives read-before-write on a same-word collision.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            rd_data_reg <= mem[req_idx];
        end
    end

    generate
        if (LATENCY == 2) begin : g_lat2
            logic              s1_valid_reg;
            logic [ADDR_W-1:0] s1_pc_reg;
            logic              s1_err_reg;
            logic              out_valid_reg;
            logic [ADDR_W-1:0] out_pc_reg;
            logic              out_err_reg;
            logic [DATA_W-1:0] out_data_reg;
            logic              adv_out;
            logic              adv_s1;

            assign adv_out   = !out_valid_reg || rsp_ready;
            assign adv_s1    = !s1_valid_reg || adv_out;
            assign req_ready = adv_s1;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_valid_reg <= 1'b0;
                    s1_pc_reg    <= '0;
                    s1_err_reg   <= 1'b0;
                end else if (adv_s1) begin
                    s1_valid_reg <= req_valid;
                    s1_pc_reg    <= req_pc;
                    s1_err_reg   <= req_bad;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid_reg <= 1'b0;
                    out_pc_reg    <= '0;
                    out_err_reg   <= 1'b0;
                    out_data_reg  <= '0;
                end else if (adv_out) begin
                    out_valid_reg <= s1_valid_reg;
                    out_pc_reg    <= s1_pc_reg;
                    out_err_reg   <= s1_err_reg;
                    out_data_reg  <= s1_err_reg ? '0 : rd_data_reg;
                end
            end

            assign rsp_valid = out_valid_reg;
            assign rsp_pc    = out_pc_reg;
            assign rsp_err   = out_err_reg;
            assign rsp_instr = out_data_reg;
        end else begin : g_lat1
            logic              out_valid_reg;
            logic [ADDR_W-1:0] out_pc_reg;
            logic              out_err_reg;
            logic              adv_out;

            assign adv_out   = !out_valid_reg || rsp_ready;
            assign req_ready = adv_out;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid_reg <= 1'b0;
                    out_pc_reg    <= '0;
                    out_err_reg   <= 1'b0;
                end else if (adv_out) begin
                    out_valid_reg <= req_valid;
                    out_pc_reg    <= req_pc;
                    out_err_reg   <= req_bad;
                end
            end

            // rd_data_reg only changes on a fire, which cannot happen while the output stalls.
            assign rsp_valid = out_valid_reg;
            assign rsp_pc    = out_pc_reg;
            assign rsp_err   = out_err_reg;
            assign rsp_instr = (out_valid_reg && !out_err_reg) ? rd_data_reg : '0;
        end
    endgenerate

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Directed and random stimulus for instr_mem_pipe, checked against a queue-based
// reference model of the pipe (capacity LATENCY, in-order, read-before-write memory).
module tb_instr_mem_pipe;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 64;
    localparam int LAT    = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_pc = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_instr;
    logic [ADDR_W-1:0] rsp_pc;
    logic              rsp_err;
    logic              ld_en = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [DATA_W-1:0] ld_data = '0;

    instr_mem_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
        .rsp_pc(rsp_pc), .rsp_err(rsp_err),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
        int          acc;
    } item_t;

    item_t       q[$];
    logic [31:0] ref_mem [DEPTH];
    int          cyc = 0;
    int          last_leave = 0;
    int          total = 0;
    int          bad = 0;

    function automatic bit good_addr(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ((a >> 2) < 32'(DEPTH));
    endfunction

    function automatic logic [31:0] word_init(input int i);
        return {16'h2010 + 16'(i), 16'h0004 + 16'(16 * i)};
    endfunction

    function automatic logic [31:0] rand_addr();
        int r;
        r = int'($urandom_range(0, 15));
        if (r == 0) return {24'(0), 6'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
        if (r == 1) return 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 7));
        if (r == 2) return 32'h8000_0000 | 32'(4 * $urandom_range(0, DEPTH - 1));
        return 32'(4 * $urandom_range(0, DEPTH - 1));
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // One clock: check outputs against the model, then advance the model and the clock.
    task automatic step();
        item_t h;
        item_t n;
        bit    exp_rdy;
        bit    exp_vld;
        int    vis;
        #1;
        exp_rdy = !(q.size() >= LAT && !rsp_ready);
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        exp_vld = 1'b0;
        if (q.size() > 0) begin
            vis = q[0].acc + LAT - 1;
            if (last_leave > vis) vis = last_leave;
            exp_vld = (cyc >= vis);
        end
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_vld));
        if (exp_vld) begin
            h = q[0];
            chk("rsp_pc", 64'(rsp_pc), 64'(h.pc));
            chk("rsp_instr", 64'(rsp_instr), 64'(h.instr));
            chk("rsp_err", 64'(rsp_err), 64'(h.err));
            if (rsp_ready) begin
                void'(q.pop_front());
                last_leave = cyc + 1;
            end
        end
        if (req_valid && exp_rdy) begin
            n.pc    = req_pc;
            n.err   = !good_addr(req_pc);
            n.instr = n.err ? 32'h0 : ref_mem[int'(req_pc >> 2)];
            n.acc   = cyc + 1;
            q.push_back(n);
        end
        if (ld_en && rst_n && good_addr(ld_addr)) ref_mem[int'(ld_addr >> 2)] = ld_data;
        $display("cyc=%0d req v/r=%0b%0b pc=%h rsp v/r=%0b%0b pc=%h instr=%h err=%0b ld=%0b@%h",
                 cyc, req_valid, req_ready, req_pc, rsp_valid, rsp_ready, rsp_pc, rsp_instr, rsp_err,
                 ld_en, ld_addr);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Reset with fetches and a load attempted; nothing may survive or be written.
    task automatic reset_check(input int hold);
        rst_n = 1'b0;
        ld_en = 1'b1; ld_addr = 32'd12; ld_data = 32'hBAD0_0000;
        req_valid = 1'b1; req_pc = 32'd0;
        #1;
        chk("rst_valid", 64'(rsp_valid), 64'(0));
        chk("rst_ready", 64'(req_ready), 64'(1));
        chk("rst_instr", 64'(rsp_instr), 64'(0));
        chk("rst_pc", 64'(rsp_pc), 64'(0));
        chk("rst_err", 64'(rsp_err), 64'(0));
        q.delete();
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            #1;
            chk("rst_hold_valid", 64'(rsp_valid), 64'(0));
            chk("rst_hold_ready", 64'(req_ready), 64'(1));
        end
        $display("cyc=%0d reset released", cyc);
        ld_en = 1'b0; req_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic fetch(input logic [31:0] pc);
        req_valid = 1'b1; req_pc = pc;
        step();
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        @(negedge clk);
        reset_check(3);

        for (int i = 0; i < DEPTH; i++) begin
            ld_en = 1'b1; ld_addr = 32'(4 * i); ld_data = word_init(i);
            step();
        end
        ld_en = 1'b0;

        // Single fetch of a loaded word.
        rsp_ready = 1'b1;
        fetch(32'd4);
        idle(3);

        // Error fetches and ignored loads.
        fetch(32'd6);
        fetch(32'(4 * DEPTH));
        fetch(32'h8000_0004);
        idle(3);
        ld_en = 1'b1; ld_addr = 32'(4 * DEPTH); ld_data = 32'hFFFF_FFFF; step();
        ld_addr = 32'h8000_0000; step();
        ld_addr = 32'd9; step();
        ld_en = 1'b0;
        fetch(32'd0);
        fetch(32'd8);
        idle(3);

        // Back-to-back stream.
        fetch(32'd0); fetch(32'd4); fetch(32'd8); fetch(32'd12);
        idle(4);

        // Output stall with the pipe full, then release.
        rsp_ready = 1'b0;
        fetch(32'd0);
        fetch(32'd4);
        req_valid = 1'b1; req_pc = 32'd8;
        idle(3);
        req_valid = 1'b0; rsp_ready = 1'b1;
        idle(4);

        // Same-cycle load and fetch of one word.
        ld_en = 1'b1; ld_addr = 32'd8; ld_data = 32'hDEAD_BEEF;
        fetch(32'd8);
        ld_en = 1'b0;
        fetch(32'd8);
        idle(3);

        // Reset with two fetches in flight.
        rsp_ready = 1'b0;
        fetch(32'd16);
        fetch(32'd20);
        reset_check(2);
        rsp_ready = 1'b1;
        idle(3);
        fetch(32'd24);
        idle(3);

        for (int i = 0; i < 400; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            req_pc    = rand_addr();
            ld_en     = ($urandom_range(0, 7) == 0);
            ld_addr   = rand_addr();
            ld_data   = $urandom;
            step();
        end

        req_valid = 1'b0; ld_en = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() > 0; i++) step();
        chk("drain_empty", 64'(q.size()), 64'(0));
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
